sd_block_responder: RTL

SD_BLOCK_RESPONDER -- requirements
Module: sd_block_responder

---
 rtl/sd_pkg.sv | 20 ++
 rtl/sd_block_responder.sv | 107 ++++++++++
 2 files changed

// File: rtl/sd_pkg.sv
// Shared definitions for the SD block responder: block geometry and FSM states.
package sd_pkg;

  localparam int BLK_BYTES = 512;
  localparam int IDX_W     = 9;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK_BYTES - 1);

  typedef enum logic [3:0] {
    IDLE,
    ACCEPT,
    RD_REQ,
    RD_PUT,
    WR_ADDR,
    WR_CAP,
    WR_REQ,
    DONE,
    GAP_WAIT
  } sd_state_t;

endpackage

// File: rtl/sd_block_responder.sv
// SD block responder: moves one 512-byte block per request between the core's
// sector buffer and a byte-wide backing memory, one byte per memory handshake.
module sd_block_responder
  import sd_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int GAP    = 2
) (
  input  logic              clk_sys,
  input  logic              nRESET,
  input  logic [31:0]       sd_lba,
  input  logic              sd_rd,
  input  logic              sd_wr,
  output logic              sd_ack,
  output logic [8:0]        sd_buff_addr,
  output logic [7:0]        sd_buff_dout,
  output logic              sd_buff_wr,
  input  logic [7:0]        sd_buff_din,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  input  logic              mem_ready
);

  localparam logic [15:0] GAP_L = 16'(GAP);

  sd_state_t        state, state_nxt;
  logic [IDX_W-1:0] idx;
  logic [31:0]      lba_q;
  logic             dir_rd;
  logic [15:0]      gap_cnt;
  logic             req;
  logic             last_byte;
  logic             gap_done;

  assign req       = sd_rd | sd_wr;
  assign last_byte = (idx == IDX_LAST);
  // GAP_WAIT always lasts at least one cycle, so GAP=0 still yields a gap.
  assign gap_done  = ((gap_cnt + 16'd1) >= GAP_L);

  // State register
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic; requests are only looked at in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (req) state_nxt = ACCEPT;
      ACCEPT:   state_nxt = dir_rd ? RD_REQ : WR_ADDR;
      RD_REQ:   if (mem_ready) state_nxt = RD_PUT;
      RD_PUT:   state_nxt = last_byte ? DONE : RD_REQ;
      WR_ADDR:  state_nxt = WR_CAP;
      WR_CAP:   state_nxt = WR_REQ;
      WR_REQ:   if (mem_ready) state_nxt = last_byte ? DONE : WR_ADDR;
      DONE:     state_nxt = GAP_WAIT;
      GAP_WAIT: if (gap_done) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Registered datapath: request latch, byte index, data holding, ack, gap timer
  always_ff @(posedge clk_sys or negedge nRESET) begin
    if (!nRESET) begin
      lba_q        <= '0;
      dir_rd       <= 1'b0;
      idx          <= '0;
      sd_ack       <= 1'b0;
      sd_buff_dout <= '0;
      mem_wdata    <= '0;
      gap_cnt      <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          lba_q  <= sd_lba;
          dir_rd <= sd_rd;   // read wins when both are raised together
          idx    <= '0;
        end
        ACCEPT:   sd_ack <= 1'b1;
        RD_REQ:   if (mem_ready) sd_buff_dout <= mem_rdata;
        RD_PUT:   if (!last_byte) idx <= idx + 1'b1;
        WR_CAP:   mem_wdata <= sd_buff_din;  // core data lags the address by one cycle
        WR_REQ:   if (mem_ready && !last_byte) idx <= idx + 1'b1;
        DONE: begin
          sd_ack  <= 1'b0;
          gap_cnt <= '0;
        end
        GAP_WAIT: gap_cnt <= gap_cnt + 16'd1;
        default: ;
      endcase
    end
  end

  // Moore outputs; mem_rd and mem_wr come from distinct states so never overlap
  always_comb begin
    mem_rd       = (state == RD_REQ);
    mem_wr       = (state == WR_REQ);
    sd_buff_wr   = (state == RD_PUT);
    sd_buff_addr = idx;
    mem_addr     = ADDR_W'({lba_q, 9'b0} + 41'(idx));
  end

endmodule
